mul_iter: RTL

- Iterative 32x32->64 multiplier in the EX-stage functional-unit group; the multiplicative counterpart of the multi-cycle divider.
- Radix-4 Booth, one Booth digit per cycle; serves MUL.W / MULH.W / MULH.WU.
- Operands and signedness are latched at start, so upstream may change them while busy.
- Result holds stable after the completion pulse until the next start.

---
 rtl/mul_pkg.sv | 36 +++
 rtl/booth_r4_sel.sv | 32 +++
 rtl/mul_iter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative radix-4 Booth multiplier.
package mul_pkg;

    localparam int MUL_XLEN  = 32;
    localparam int MUL_OPW   = MUL_XLEN + 2;        // operand after sign/zero extension
    localparam int MUL_ITER  = MUL_OPW / 2;         // one Booth digit per cycle
    localparam int MUL_PPW   = MUL_OPW + 1;         // partial product and upper accumulator half
    localparam int MUL_ACC_W = MUL_PPW + MUL_OPW;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    function automatic booth_digit_e booth_recode(input logic [2:0] window);
        booth_digit_e digit;
        case (window)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth partial-product selector: recodes a 3-bit window and
// returns 0, +/-1x or +/-2x of the multiplicand as a two's complement value.
module booth_r4_sel
    import mul_pkg::*;
#(
    parameter int OPW = MUL_OPW
) (
    input  logic [2:0]   window,
    input  logic [OPW-1:0] mcand,
    output logic [OPW:0]   pp
);

    booth_digit_e digit;
    logic [OPW:0] m1;
    logic [OPW:0] m2;

    assign digit = booth_recode(window);
    assign m1    = {mcand[OPW-1], mcand};
    assign m2    = {mcand, 1'b0};

    always_comb begin
        pp = '0;
        case (digit)
            POS1:    pp = m1;
            POS2:    pp = m2;
            NEG1:    pp = -m1;
            NEG2:    pp = -m2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/mul_iter.sv
// Iterative XLEN x XLEN -> 2*XLEN multiplier, one radix-4 Booth digit per cycle.
// Fixed latency: start sampled at T, complete pulses at T+18.
module mul_iter
    import mul_pkg::*;
#(
    parameter int XLEN = MUL_XLEN
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            mul,
    input  logic            mul_signed,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            flush,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            busy,
    output logic            complete
);

    localparam int OPW   = XLEN + 2;
    localparam int PPW   = OPW + 1;
    localparam int ACC_W = PPW + OPW;
    localparam int ITER  = OPW / 2;
    localparam int CW    = $clog2(ITER);

    state_e                   state;
    logic [OPW-1:0]           mcand;
    logic [ACC_W-1:0]         acc;
    logic                     y_prev;
    logic [CW-1:0]            count;

    logic [OPW-1:0]           x_ext;
    logic [OPW-1:0]           y_ext;
    logic [PPW-1:0]           pp;
    logic [PPW-1:0]           upper_sum;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_next;

    assign x_ext = mul_signed ? {{2{x[XLEN-1]}}, x} : {2'b00, x};
    assign y_ext = mul_signed ? {{2{y[XLEN-1]}}, y} : {2'b00, y};

    // The multiplier sits in the low half of acc and shifts out two bits per digit.
    booth_r4_sel #(
        .OPW (OPW)
    ) u_sel (
        .window ({acc[1:0], y_prev}),
        .mcand  (mcand),
        .pp     (pp)
    );

    assign upper_sum = acc[ACC_W-1 -: PPW] + pp;
    assign acc_sum   = {upper_sum, acc[OPW-1:0]};
    assign acc_next  = acc_sum >>> 2;

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            mcand    <= '0;
            acc      <= '0;
            y_prev   <= 1'b0;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            complete <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (mul && !flush) begin
                        mcand  <= x_ext;
                        acc    <= {{PPW{1'b0}}, y_ext};
                        y_prev <= 1'b0;
                        count  <= CW'(ITER - 1);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        y_prev <= acc[1];
                        count  <= count - 1'b1;
                        if (count == '0) begin
                            hi       <= acc_next[2*XLEN-1:XLEN];
                            lo       <= acc_next[XLEN-1:0];
                            complete <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
